// File: rtl/mips_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_mem_pkg
// Description : Shared types and constants for the data-memory access
//               sequencer. Provides the FSM state encoding, default bus
//               widths and the word-alignment mask.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_mem_pkg;

  localparam int c_ADDR_W = 32;
  localparam int c_DATA_W = 32;

  // Address bits that must be zero for a word access.
  localparam logic [1:0] c_ALIGN_MASK = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2,
    ABORT  = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/access_timer.sv
`default_nettype none
// ============================================================================
// Module      : access_timer
// Description : Clear/enable cycle counter. Flags terminal count when the
//               counter holds TIMEOUT-1. The counter does not wrap.
// Ports       : clk, rst       - clock, synchronous active-high reset
//               i_clear        - force count to zero (priority over enable)
//               i_enable       - advance count by one
//               o_terminal     - count == TIMEOUT-1
// Revision    : 1.0 - initial release
// ============================================================================
module access_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_terminal
);

  localparam int CNT_W = $clog2(TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] c_TERM = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && (r_count != c_TERM)) begin
      // Saturate at terminal count; the FSM leaves ACCESS there anyway.
      r_count <= r_count + 1'b1;
    end
  end

  assign o_terminal = (r_count == c_TERM);

endmodule
`default_nettype wire

// File: rtl/dmem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dmem_access_ctrl
// Description : Sequences load/store instructions leaving EX/MEM onto a
//               variable-latency data memory via a req/ready handshake.
//               Stalls the upstream pipeline while an access is in flight,
//               bubbles MEM/WB during stalls and aborts on timeout or on an
//               illegal (misaligned / read+write) request.
// Ports       : clk, rst                       - clock, sync active-high reset
//               MemRead_in, MemWrite_in,
//               RegWrite_in                    - EX/MEM control flags
//               D_MEM_addr_in, D_MEM_write_data_in - EX/MEM address / data
//               mem_req, mem_we, mem_addr,
//               mem_wdata                      - registered request to D_MEM
//               mem_rdata, mem_ready           - D_MEM response
//               stall                          - hold upstream pipeline
//               RegWrite_out                   - gated RegWrite to MEM/WB
//               D_MEM_read_data_out            - captured load data
//               access_err                     - one-cycle error pulse
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_access_ctrl
  import mips_mem_pkg::*;
#(
  parameter int ADDR_W  = c_ADDR_W,
  parameter int DATA_W  = c_DATA_W,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MemRead_in,
  input  logic              MemWrite_in,
  input  logic              RegWrite_in,
  input  logic [ADDR_W-1:0] D_MEM_addr_in,
  input  logic [DATA_W-1:0] D_MEM_write_data_in,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              stall,
  output logic              RegWrite_out,
  output logic [DATA_W-1:0] D_MEM_read_data_out,
  output logic              access_err
);

  state_t r_state;
  state_t w_nextState;

  logic              r_memReq;
  logic              r_memWe;
  logic [ADDR_W-1:0] r_memAddr;
  logic [DATA_W-1:0] r_memWdata;
  logic [DATA_W-1:0] r_readData;

  logic w_anyOp;
  logic w_misaligned;
  logic w_legalOp;
  logic w_illegalOp;
  logic w_timeout;
  logic w_stall;
  logic w_regWrite;
  logic w_accessErr;

  // Request classification on the instruction currently in EX/MEM.
  assign w_anyOp      = MemRead_in | MemWrite_in;
  assign w_misaligned = |(D_MEM_addr_in[1:0] & c_ALIGN_MASK);
  assign w_legalOp    = (MemRead_in ^ MemWrite_in) && !w_misaligned;
  assign w_illegalOp  = w_anyOp && !w_legalOp;

  // Counter is only meaningful in ACCESS; holding it cleared elsewhere
  // guarantees every access starts its timeout window at zero.
  access_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .i_clear    (r_state != ACCESS),
    .i_enable   ((r_state == ACCESS) && !mem_ready),
    .o_terminal (w_timeout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_stall     = 1'b0;
    w_regWrite  = RegWrite_in;
    w_accessErr = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_legalOp) begin
          w_stall     = 1'b1;
          w_regWrite  = 1'b0;
          w_nextState = ACCESS;
        end else if (w_illegalOp) begin
          // Illegal op retires as a bubble without touching memory.
          w_regWrite  = 1'b0;
          w_accessErr = 1'b1;
        end
      end
      ACCESS: begin
        w_stall    = 1'b1;
        w_regWrite = 1'b0;
        // Ready takes priority over a coincident timeout.
        if (mem_ready) begin
          w_nextState = DONE;
        end else if (w_timeout) begin
          w_nextState = ABORT;
        end
      end
      DONE: begin
        w_nextState = IDLE;
      end
      ABORT: begin
        w_regWrite  = 1'b0;
        w_accessErr = 1'b1;
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Request and read-data latches.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_memReq   <= 1'b0;
      r_memWe    <= 1'b0;
      r_memAddr  <= '0;
      r_memWdata <= '0;
      r_readData <= '0;
    end else begin
      if ((r_state == IDLE) && w_legalOp) begin
        r_memReq   <= 1'b1;
        r_memWe    <= MemWrite_in;
        r_memAddr  <= D_MEM_addr_in;
        r_memWdata <= D_MEM_write_data_in;
      end
      if (r_state == ACCESS) begin
        if (mem_ready) begin
          r_memReq <= 1'b0;
          if (!r_memWe) begin
            r_readData <= mem_rdata;
          end
        end else if (w_timeout) begin
          r_memReq <= 1'b0;
        end
      end
    end
  end

  assign mem_req             = r_memReq;
  assign mem_we              = r_memWe;
  assign mem_addr            = r_memAddr;
  assign mem_wdata           = r_memWdata;
  assign D_MEM_read_data_out = r_readData;
  assign stall               = w_stall;
  assign RegWrite_out        = w_regWrite;
  assign access_err          = w_accessErr;

endmodule
`default_nettype wire

// File: doc/dmem_access_ctrl.md
# dmem_access_ctrl

Sequencer between the EX/MEM pipeline register and a variable-latency data memory. It detects load/store instructions leaving EX/MEM, issues one request per instruction to D_MEM via a req/ready handshake, stalls the upstream pipeline while the access is outstanding, and presents read data to the MEM/WB register. It also injects a bubble into MEM/WB during stalls and aborts accesses that time out or are misaligned.

## Interface
- ADDR_W, 32, byte address width
- DATA_W, 32, data width (word accesses only)
- TIMEOUT, 16, max ACCESS cycles waiting for mem_ready before abort (>=1)

- clk  in  1  pipeline clock
- rst  in  1  synchronous, active-high reset
- MemRead_in  in  1  EX/MEM load flag
- MemWrite_in  in  1  EX/MEM store flag
- RegWrite_in  in  1  EX/MEM register-write flag
- D_MEM_addr_in  in  ADDR_W  EX/MEM ALU result (address)
- D_MEM_write_data_in  in  DATA_W  EX/MEM store data
- mem_req  out  1  request to D_MEM, registered
- mem_we  out  1  1 = write, valid with mem_req
- mem_addr  out  ADDR_W  latched address, valid with mem_req
- mem_wdata  out  DATA_W  latched store data, valid with mem_req
- mem_rdata  in  DATA_W  D_MEM read data, valid when mem_ready
- mem_ready  in  1  D_MEM completion, sampled only in ACCESS
- stall  out  1  hold PC, IF/ID, ID/EX, EX/MEM
- RegWrite_out  out  1  gated RegWrite to MEM/WB (0 = bubble)
- D_MEM_read_data_out  out  DATA_W  captured load data to MEM/WB
- access_err  out  1  one-cycle pulse: misaligned, read+write both set, or timeout

## Operation
- States: IDLE, ACCESS, DONE, ABORT.
- IDLE, no memory op: stall=0, RegWrite_out=RegWrite_in, no request.
- IDLE, op present (exactly one of MemRead_in/MemWrite_in, addr[1:0]==0): stall=1 combinationally, RegWrite_out=0; at edge latch addr/wdata/we, mem_req<=1, cnt<=0, go ACCESS.
- IDLE, illegal op (addr[1:0]!=0 or both flags set): no request, stall=0, RegWrite_out=0, access_err=1 this cycle; instruction retires as bubble.
- ACCESS: stall=1, RegWrite_out=0, mem_req=1. If mem_ready: capture mem_rdata (loads only), mem_req<=0, go DONE. Else if cnt==TIMEOUT-1: mem_req<=0, go ABORT. Else cnt<=cnt+1.
- DONE: stall=0, RegWrite_out=RegWrite_in, D_MEM_read_data_out holds captured data; pipeline advances at this edge; go IDLE. Next instruction evaluated in IDLE, so no re-issue.
- ABORT: stall=0, RegWrite_out=0, access_err=1; go IDLE. Store side effects undefined.
- D_MEM_read_data_out changes only on capture; stores leave it unchanged.

## Timing
- Reset values: state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, D_MEM_read_data_out=0, cnt=0; stall/RegWrite_out/access_err then follow IDLE rules from inputs.
- rst in any state (incl. ACCESS mid-handshake): next cycle IDLE, mem_req=0, no access_err, no capture.
- Minimum memory-op latency: mem_ready in first ACCESS cycle -> 2 stall cycles (IDLE, ACCESS), data at MEM/WB after DONE edge.
- Latency with mem_ready after k ACCESS cycles (k=1..TIMEOUT): k+1 stall cycles.
- Timeout: TIMEOUT ACCESS cycles without ready -> ABORT; mem_ready arriving in ABORT/IDLE/DONE ignored.
- mem_ready and timeout in same cycle: ready wins.
- Back-to-back memory ops: DONE -> IDLE -> ACCESS, one stall-free cycle (DONE) between them.
- cnt width = $clog2(TIMEOUT)+1, no wrap.

## Structure
- Package mips_mem_pkg: state typedef (IDLE/ACCESS/DONE/ABORT), ADDR_W/DATA_W defaults, alignment mask constant.
- Sub-module access_timer: clear/enable counter with terminal-count output at TIMEOUT-1.
- Top: FSM, request/data latches, combinational stall/RegWrite_out/access_err.

## Test plan
- Load addr 0x100, mem_ready in first ACCESS cycle, mem_rdata=0xDEADBEEF -> stall high 2 cycles, one mem_req pulse with we=0 addr=0x100, D_MEM_read_data_out=0xDEADBEEF, RegWrite_out=1 in DONE.
- Store addr 0x40 data 0x12345678, ready after 3 cycles -> stall 4 cycles, mem_we=1, mem_wdata=0x12345678, read data unchanged, RegWrite_out=0 throughout if RegWrite_in=0.
- Load, mem_ready never (TIMEOUT=16) -> exactly 16 ACCESS cycles, then ABORT: access_err pulse 1 cycle, RegWrite_out=0, mem_req low.
- Load addr 0x102, and separately MemRead_in=MemWrite_in=1 at 0x100 -> no mem_req, stall=0, access_err=1, RegWrite_out=0.
- rst asserted in second ACCESS cycle -> next cycle IDLE, mem_req=0, all registered outputs at reset values, no access_err.
- Two consecutive loads, ready immediate -> two requests with exactly one non-stall cycle between stall windows, each load data delivered once.
